// File: rtl/multi_cycle_control_if.sv
// Control bus between the multi-cycle MIPS controller and its datapath.
// The controller uses the master modport; the datapath (or bench) uses slave.
interface multi_cycle_control_if #(
  parameter int unsigned CNT_W = 32
);
  logic [5:0]       opCode;
  logic             zero;
  logic             mem_ready;
  logic             pc_write;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       pc_source;
  logic             instr_done;
  logic [CNT_W-1:0] instr_count;
  logic [3:0]       state;
  logic             illegal_instr;

  modport master (
    input  opCode, zero, mem_ready,
    output pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
           instr_done, instr_count, state, illegal_instr
  );

  modport slave (
    output opCode, zero, mem_ready,
    input  pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
           instr_done, instr_count, state, illegal_instr
  );
endinterface

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS control FSM: fetch/decode/execute/memory/writeback
// sequencing with variable-latency memory (mem_ready) and a retired
// instruction counter. Optional macro ILLEGAL_TRAP_EN adds a sticky TRAP
// state for unknown opcodes; without it unknown opcodes retire as NOPs.
module multi_cycle_control #(
  parameter int unsigned CNT_W = 32
) (
  input logic                 clk,
  input logic                 reset,
  multi_cycle_control_if.master bus
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    EXEC_R   = 4'd6,
    R_WB     = 4'd7,
    EXEC_I   = 4'd8,
    I_WB     = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11
`ifdef ILLEGAL_TRAP_EN
    ,TRAP    = 4'd12
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;

  logic       pc_write_c, i_or_d_c, mem_read_c, mem_write_c, ir_write_c;
  logic       reg_dst_c, mem_to_reg_c, reg_write_c, alu_src_a_c, instr_done_c;
  logic [1:0] alu_src_b_c, alu_op_c, pc_source_c;

  // Next-state and control decode; everything stays 0 while reset is high
  always_comb begin
    state_d      = state_q;
    pc_write_c   = 1'b0;
    i_or_d_c     = 1'b0;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    ir_write_c   = 1'b0;
    reg_dst_c    = 1'b0;
    mem_to_reg_c = 1'b0;
    reg_write_c  = 1'b0;
    alu_src_a_c  = 1'b0;
    alu_src_b_c  = 2'b00;
    alu_op_c     = 2'b00;
    pc_source_c  = 2'b00;
    instr_done_c = 1'b0;
    if (!reset) begin
      case (state_q)
        FETCH: begin
          mem_read_c  = 1'b1;
          alu_src_b_c = 2'b01;
          if (bus.mem_ready) begin
            ir_write_c = 1'b1;
            pc_write_c = 1'b1;
            state_d    = DECODE;
          end
        end
        DECODE: begin
          alu_src_b_c = 2'b11;
          case (bus.opCode)
            OP_LW, OP_SW:             state_d = MEM_ADDR;
            OP_R:                     state_d = EXEC_R;
            OP_BEQ:                   state_d = BRANCH;
            OP_J:                     state_d = JUMP;
            OP_ADDI, OP_ANDI, OP_ORI: state_d = EXEC_I;
            default: begin
`ifdef ILLEGAL_TRAP_EN
              state_d = TRAP;
`else
              instr_done_c = 1'b1;
              state_d      = FETCH;
`endif
            end
          endcase
        end
        MEM_ADDR: begin
          alu_src_a_c = 1'b1;
          alu_src_b_c = 2'b10;
          state_d     = (bus.opCode == OP_SW) ? MEM_WR : MEM_RD;
        end
        MEM_RD: begin
          mem_read_c = 1'b1;
          i_or_d_c   = 1'b1;
          if (bus.mem_ready) state_d = MEM_WB;
        end
        MEM_WB: begin
          mem_to_reg_c = 1'b1;
          reg_write_c  = 1'b1;
          instr_done_c = 1'b1;
          state_d      = FETCH;
        end
        MEM_WR: begin
          mem_write_c = 1'b1;
          i_or_d_c    = 1'b1;
          if (bus.mem_ready) begin
            instr_done_c = 1'b1;
            state_d      = FETCH;
          end
        end
        EXEC_R: begin
          alu_src_a_c = 1'b1;
          alu_op_c    = 2'b10;
          state_d     = R_WB;
        end
        R_WB: begin
          reg_dst_c    = 1'b1;
          reg_write_c  = 1'b1;
          instr_done_c = 1'b1;
          state_d      = FETCH;
        end
        EXEC_I: begin
          alu_src_a_c = 1'b1;
          alu_src_b_c = 2'b10;
          alu_op_c    = 2'b10;
          state_d     = I_WB;
        end
        I_WB: begin
          reg_write_c  = 1'b1;
          instr_done_c = 1'b1;
          state_d      = FETCH;
        end
        BRANCH: begin
          alu_src_a_c  = 1'b1;
          alu_op_c     = 2'b01;
          pc_source_c  = 2'b01;
          pc_write_c   = bus.zero;
          instr_done_c = 1'b1;
          state_d      = FETCH;
        end
        JUMP: begin
          pc_source_c  = 2'b10;
          pc_write_c   = 1'b1;
          instr_done_c = 1'b1;
          state_d      = FETCH;
        end
`ifdef ILLEGAL_TRAP_EN
        TRAP: state_d = TRAP;
`endif
        default: state_d = FETCH;
      endcase
    end
  end

  assign instr_count_d = instr_count_q + CNT_W'(instr_done_c);

  // State and retired-instruction counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FETCH;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      instr_count_q <= instr_count_d;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_instr_q, illegal_instr_d;

  assign illegal_instr_d = illegal_instr_q | (state_d == TRAP);

  // Sticky illegal-instruction flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) illegal_instr_q <= 1'b0;
    else       illegal_instr_q <= illegal_instr_d;
  end

  assign bus.illegal_instr = illegal_instr_q;
`else
  assign bus.illegal_instr = 1'b0;
`endif

  assign bus.pc_write    = pc_write_c;
  assign bus.i_or_d      = i_or_d_c;
  assign bus.mem_read    = mem_read_c;
  assign bus.mem_write   = mem_write_c;
  assign bus.ir_write    = ir_write_c;
  assign bus.reg_dst     = reg_dst_c;
  assign bus.mem_to_reg  = mem_to_reg_c;
  assign bus.reg_write   = reg_write_c;
  assign bus.alu_src_a   = alu_src_a_c;
  assign bus.alu_src_b   = alu_src_b_c;
  assign bus.alu_op      = alu_op_c;
  assign bus.pc_source   = pc_source_c;
  assign bus.instr_done  = instr_done_c;
  assign bus.instr_count = instr_count_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Bench for multi_cycle_control: vector table, directed corner sequences
// and a randomized instruction stream against a step-list reference model.
module tb_multi_cycle_control;

  localparam int unsigned CNT_W = 4;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  // mux vector: {i_or_d, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source}
  localparam logic [9:0] M_0   = 10'b0000000000;
  localparam logic [9:0] M_F   = 10'b0000010000;
  localparam logic [9:0] M_D   = 10'b0000110000;
  localparam logic [9:0] M_MA  = 10'b0001100000;
  localparam logic [9:0] M_MEM = 10'b1000000000;
  localparam logic [9:0] M_WB  = 10'b0010000000;
  localparam logic [9:0] M_ER  = 10'b0001001000;
  localparam logic [9:0] M_RWB = 10'b0100000000;
  localparam logic [9:0] M_EI  = 10'b0001101000;
  localparam logic [9:0] M_BR  = 10'b0001000101;
  localparam logic [9:0] M_J   = 10'b0000000010;

  // write vector: {pc_write, ir_write, mem_read, mem_write, reg_write}
  localparam logic [4:0] W_0   = 5'b00000;
  localparam logic [4:0] W_F   = 5'b11100;
  localparam logic [4:0] W_RD  = 5'b00100;
  localparam logic [4:0] W_WR  = 5'b00010;
  localparam logic [4:0] W_RW  = 5'b00001;
  localparam logic [4:0] W_PC  = 5'b10000;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  multi_cycle_control_if #(.CNT_W(CNT_W)) bus ();

  multi_cycle_control #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       z;
    logic       mr;
    int         st;
    logic [4:0] wr;
    logic [9:0] mux;
    logic       done;
    int         cnt;
  } vec_t;

  vec_t tbl[$];

  // reference model state for the random phase
  int         path[$];
  int         idx;
  int         exp_cnt;
  logic [5:0] cur_op;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic [5:0] op, input logic z, input logic mr);
    reset         = r;
    bus.opCode    = op;
    bus.zero      = z;
    bus.mem_ready = mr;
  endtask

  function automatic logic [4:0] act_wr();
    return {bus.pc_write, bus.ir_write, bus.mem_read, bus.mem_write, bus.reg_write};
  endfunction

  function automatic logic [9:0] act_mux();
    return {bus.i_or_d, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a,
            bus.alu_src_b, bus.alu_op, bus.pc_source};
  endfunction

  task automatic check_all(input string tag, input int st, input logic [4:0] wr,
                           input logic [9:0] mux, input logic done, input int cnt);
    chk({tag, ".state"}, 32'(bus.state), 32'(st));
    chk({tag, ".wr"},    32'(act_wr()),  32'(wr));
    chk({tag, ".mux"},   32'(act_mux()), 32'(mux));
    chk({tag, ".done"},  32'(bus.instr_done), 32'(done));
    chk({tag, ".cnt"},   32'(bus.instr_count), 32'(cnt));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, OP_R, 1'b0, 1'b1);
    tick();
    tick();
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ANDI, OP_ORI};
  endfunction

  // Spec step lists per instruction class
  task automatic new_instr();
    int sel;
    logic [5:0] op;
`ifdef ILLEGAL_TRAP_EN
    sel = $urandom_range(0, 7);
`else
    sel = $urandom_range(0, 8);
`endif
    case (sel)
      0: op = OP_R;    1: op = OP_LW;   2: op = OP_SW;   3: op = OP_BEQ;
      4: op = OP_J;    5: op = OP_ADDI; 6: op = OP_ANDI; 7: op = OP_ORI;
      default: begin
        op = 6'($urandom);
        while (is_legal(op)) op = 6'($urandom);
      end
    endcase
    cur_op = op;
    idx    = 0;
    path   = {0, 1};
    if (op == OP_LW)                    path = {0, 1, 2, 3, 4};
    else if (op == OP_SW)               path = {0, 1, 2, 5};
    else if (op == OP_R)                path = {0, 1, 6, 7};
    else if (op inside {OP_ADDI, OP_ANDI, OP_ORI}) path = {0, 1, 8, 9};
    else if (op == OP_BEQ)              path = {0, 1, 10};
    else if (op == OP_J)                path = {0, 1, 11};
  endtask

  function automatic bit is_mem_wait(input int st);
    return (st == 0) || (st == 3) || (st == 5);
  endfunction

  function automatic logic [4:0] exp_wr(input int st, input logic z, input logic mr);
    case (st)
      0:       return mr ? W_F : W_RD;
      3:       return W_RD;
      4, 7, 9: return W_RW;
      5:       return W_WR;
      10:      return z ? W_PC : W_0;
      11:      return W_PC;
      default: return W_0;
    endcase
  endfunction

  function automatic logic [9:0] exp_mux(input int st);
    case (st)
      0: return M_F;    1: return M_D;   2: return M_MA;  3: return M_MEM;
      4: return M_WB;   5: return M_MEM; 6: return M_ER;  7: return M_RWB;
      8: return M_EI;   9: return M_0;   10: return M_BR; 11: return M_J;
      default: return M_0;
    endcase
  endfunction

  initial begin
    errors = 0;
    checks = 0;

    // rst, op, zero, mem_ready, state, wr, mux, done, count
    tbl.push_back('{1'b1, OP_LW,   1'b0, 1'b1, 0,  W_0,  M_0,   1'b0, 0});
    tbl.push_back('{1'b0, OP_LW,   1'b0, 1'b1, 0,  W_F,  M_F,   1'b0, 0});
    tbl.push_back('{1'b0, OP_LW,   1'b0, 1'b1, 1,  W_0,  M_D,   1'b0, 0});
    tbl.push_back('{1'b0, OP_LW,   1'b0, 1'b1, 2,  W_0,  M_MA,  1'b0, 0});
    tbl.push_back('{1'b0, OP_LW,   1'b0, 1'b1, 3,  W_RD, M_MEM, 1'b0, 0});
    tbl.push_back('{1'b0, OP_LW,   1'b0, 1'b1, 4,  W_RW, M_WB,  1'b1, 0});
    tbl.push_back('{1'b0, OP_R,    1'b0, 1'b1, 0,  W_F,  M_F,   1'b0, 1});
    tbl.push_back('{1'b0, OP_R,    1'b0, 1'b1, 1,  W_0,  M_D,   1'b0, 1});
    tbl.push_back('{1'b0, OP_R,    1'b0, 1'b1, 6,  W_0,  M_ER,  1'b0, 1});
    tbl.push_back('{1'b0, OP_R,    1'b0, 1'b1, 7,  W_RW, M_RWB, 1'b1, 1});
    tbl.push_back('{1'b0, OP_ADDI, 1'b0, 1'b1, 0,  W_F,  M_F,   1'b0, 2});
    tbl.push_back('{1'b0, OP_ADDI, 1'b0, 1'b1, 1,  W_0,  M_D,   1'b0, 2});
    tbl.push_back('{1'b0, OP_ADDI, 1'b0, 1'b1, 8,  W_0,  M_EI,  1'b0, 2});
    tbl.push_back('{1'b0, OP_ADDI, 1'b0, 1'b1, 9,  W_RW, M_0,   1'b1, 2});
    tbl.push_back('{1'b0, OP_BEQ,  1'b1, 1'b1, 0,  W_F,  M_F,   1'b0, 3});
    tbl.push_back('{1'b0, OP_BEQ,  1'b1, 1'b1, 1,  W_0,  M_D,   1'b0, 3});
    tbl.push_back('{1'b0, OP_BEQ,  1'b1, 1'b1, 10, W_PC, M_BR,  1'b1, 3});
    tbl.push_back('{1'b0, OP_BEQ,  1'b0, 1'b1, 0,  W_F,  M_F,   1'b0, 4});
    tbl.push_back('{1'b0, OP_BEQ,  1'b0, 1'b1, 1,  W_0,  M_D,   1'b0, 4});
    tbl.push_back('{1'b0, OP_BEQ,  1'b0, 1'b1, 10, W_0,  M_BR,  1'b1, 4});
    tbl.push_back('{1'b0, OP_J,    1'b0, 1'b1, 0,  W_F,  M_F,   1'b0, 5});
    tbl.push_back('{1'b0, OP_J,    1'b0, 1'b1, 1,  W_0,  M_D,   1'b0, 5});
    tbl.push_back('{1'b0, OP_J,    1'b0, 1'b1, 11, W_PC, M_J,   1'b1, 5});
    tbl.push_back('{1'b0, OP_SW,   1'b0, 1'b1, 0,  W_F,  M_F,   1'b0, 6});
    tbl.push_back('{1'b0, OP_SW,   1'b0, 1'b1, 1,  W_0,  M_D,   1'b0, 6});
    tbl.push_back('{1'b0, OP_SW,   1'b0, 1'b1, 2,  W_0,  M_MA,  1'b0, 6});
    tbl.push_back('{1'b0, OP_SW,   1'b0, 1'b1, 5,  W_WR, M_MEM, 1'b1, 6});
    tbl.push_back('{1'b0, OP_LW,   1'b0, 1'b0, 0,  W_RD, M_F,   1'b0, 7});
    tbl.push_back('{1'b0, OP_LW,   1'b0, 1'b1, 0,  W_F,  M_F,   1'b0, 7});
    tbl.push_back('{1'b0, OP_LW,   1'b0, 1'b1, 1,  W_0,  M_D,   1'b0, 7});
    tbl.push_back('{1'b0, OP_LW,   1'b0, 1'b1, 2,  W_0,  M_MA,  1'b0, 7});
    tbl.push_back('{1'b0, OP_LW,   1'b0, 1'b0, 3,  W_RD, M_MEM, 1'b0, 7});
    tbl.push_back('{1'b0, OP_LW,   1'b0, 1'b1, 3,  W_RD, M_MEM, 1'b0, 7});
    tbl.push_back('{1'b0, OP_LW,   1'b0, 1'b1, 4,  W_RW, M_WB,  1'b1, 7});
    tbl.push_back('{1'b0, OP_LW,   1'b0, 1'b1, 0,  W_F,  M_F,   1'b0, 8});
    tbl.push_back('{1'b0, OP_LW,   1'b0, 1'b1, 1,  W_0,  M_D,   1'b0, 8});
    tbl.push_back('{1'b0, OP_LW,   1'b0, 1'b1, 2,  W_0,  M_MA,  1'b0, 8});
    tbl.push_back('{1'b1, OP_LW,   1'b0, 1'b1, 3,  W_0,  M_0,   1'b0, 8});
    tbl.push_back('{1'b0, OP_LW,   1'b0, 1'b1, 0,  W_F,  M_F,   1'b0, 0});

    drive(1'b1, OP_R, 1'b0, 1'b1);
    tick();

    // Vector table
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].op, tbl[i].z, tbl[i].mr);
      @(negedge clk);
      check_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].wr, tbl[i].mux,
                tbl[i].done, tbl[i].cnt);
      chk($sformatf("vec%0d.illegal", i), 32'(bus.illegal_instr), 32'd0);
      tick();
    end

    // sw held in MEM_WR for three not-ready cycles
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, OP_SW, 1'b0, 1'b1);
      @(negedge clk);
      chk("sw_wait.pre_state", 32'(bus.state), 32'(c));
      tick();
    end
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, OP_SW, 1'b0, (c == 3));
      @(negedge clk);
      check_all($sformatf("sw_wait%0d", c), 5, W_WR, M_MEM, (c == 3), 0);
      tick();
    end
    drive(1'b0, OP_J, 1'b0, 1'b1);
    @(negedge clk);
    chk("sw_wait.back_fetch", 32'(bus.state), 32'd0);
    chk("sw_wait.cnt", 32'(bus.instr_count), 32'd1);

    // Unknown opcode
    do_reset();
    drive(1'b0, OP_BAD, 1'b0, 1'b1);
    @(negedge clk);
    chk("bad.fetch", 32'(bus.state), 32'd0);
    tick();
    @(negedge clk);
    chk("bad.decode", 32'(bus.state), 32'd1);
`ifdef ILLEGAL_TRAP_EN
    chk("bad.decode_done", 32'(bus.instr_done), 32'd0);
    tick();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_all($sformatf("trap%0d", c), 12, W_0, M_0, 1'b0, 0);
      chk($sformatf("trap%0d.illegal", c), 32'(bus.illegal_instr), 32'd1);
      tick();
    end
    do_reset();
    drive(1'b0, OP_J, 1'b0, 1'b1);
    @(negedge clk);
    chk("trap.cleared", 32'(bus.illegal_instr), 32'd0);
    chk("trap.fetch", 32'(bus.state), 32'd0);
`else
    chk("bad.decode_done", 32'(bus.instr_done), 32'd1);
    tick();
    @(negedge clk);
    chk("bad.back_fetch", 32'(bus.state), 32'd0);
    chk("bad.cnt", 32'(bus.instr_count), 32'd1);
    chk("bad.illegal", 32'(bus.illegal_instr), 32'd0);
`endif

    // Counter wrap with 16 jumps
    do_reset();
    for (int k = 0; k <= 16; k++) begin
      for (int c = 0; c < 3; c++) begin
        drive(1'b0, OP_J, 1'b0, 1'b1);
        @(negedge clk);
        if (c == 0) chk($sformatf("wrap%0d.cnt", k), 32'(bus.instr_count), 32'(k % 16));
        if (k == 16) break;
        tick();
      end
    end

    // Randomized instruction stream against the step-list model
    do_reset();
    exp_cnt = 0;
    new_instr();
    for (int n = 0; n < 3000; n++) begin
      logic z, mr, last, hold;
      int st;
      z  = 1'($urandom);
      mr = ($urandom_range(0, 3) != 0);
      drive(1'b0, cur_op, z, mr);
      @(negedge clk);
      st   = path[idx];
      hold = is_mem_wait(st) && !mr;
      last = (idx == path.size() - 1);
      check_all($sformatf("rnd%0d", n), st, exp_wr(st, z, mr), exp_mux(st),
                last && !hold, exp_cnt);
      tick();
      if (!hold) begin
        if (last) begin
          exp_cnt = (exp_cnt + 1) % 16;
          new_instr();
        end else begin
          idx++;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_cycle_control.md
Name: multi_cycle_control

Overview:
Moore/Mealy FSM that sequences the multi-cycle MIPS datapath (shared memory, IR, register file, ALU, PC) across fetch, decode, execute, memory and writeback steps. Decodes opCode into a per-instruction state path and drives every datapath enable and mux select. ALU function is requested through alu_op; the existing ALU select decoder resolves alu_op=10 from function_code/opCode. Supports a variable-latency memory through mem_ready.

Parameters:
CNT_W, 32, width of retired-instruction counter instr_count

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
opCode  in  6  IR[31:26]
zero  in  1  ALU zero flag
mem_ready  in  1  memory access completes this cycle
pc_write  out  1  PC enable, includes branch condition
i_or_d  out  1  memory address: 0=PC, 1=ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  IR load
reg_dst  out  1  write reg: 0=rt, 1=rd
mem_to_reg  out  1  write data: 0=ALUOut, 1=MDR
reg_write  out  1  register file write
alu_src_a  out  1  0=PC, 1=A
alu_src_b  out  2  00=B, 01=4, 10=signext imm, 11=signext imm<<2
alu_op  out  2  00=ADD, 01=SUB, 10=decode function_code/opCode
pc_source  out  2  00=ALU, 01=ALUOut, 10=jump target
instr_done  out  1  1-cycle pulse in final state of each instruction
instr_count  out  CNT_W  retired instructions, wraps
state  out  4  current state, debug
illegal_instr  out  1  see Optional Feature

Behaviour:
- Reset: state<=FETCH, instr_count<=0, illegal_instr<=0. While reset=1, all control outputs are forced 0.
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, j=000010, addi=001000, andi=001100, ori=001101.
- Outputs not listed for a state are 0.
- FETCH(0): mem_read, alu_src_b=01, alu_op=00, pc_source=00. If mem_ready: ir_write=1, pc_write=1, ->DECODE; else stay.
- DECODE(1): alu_src_b=11, alu_op=00 (branch target into ALUOut). Next: lw/sw->MEM_ADDR, R->EXEC_R, beq->BRANCH, j->JUMP, addi/andi/ori->EXEC_I, other->FETCH with instr_done=1.
- MEM_ADDR(2): alu_src_a=1, alu_src_b=10, alu_op=00. lw->MEM_RD, sw->MEM_WR.
- MEM_RD(3): mem_read, i_or_d. Goes ->MEM_WB when mem_ready=1, else holds.
- MEM_WB(4): mem_to_reg, reg_write, instr_done ->FETCH.
- MEM_WR(5): mem_write, i_or_d. On mem_ready: instr_done ->FETCH, else holds.
- EXEC_R(6): alu_src_a=1, alu_src_b=00, alu_op=10 ->R_WB.
- R_WB(7): reg_dst, reg_write, instr_done ->FETCH.
- EXEC_I(8): alu_src_a=1, alu_src_b=10, alu_op=10 ->I_WB.
- I_WB(9): reg_write, instr_done ->FETCH.
- BRANCH(10): alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01. pc_write=zero. instr_done ->FETCH.
- JUMP(11): pc_source=10, pc_write=1, instr_done ->FETCH.
- Latency with mem_ready=1: lw 5, sw/R/I 4, beq/j 3, unknown opcode 2 cycles. Each mem_ready=0 cycle adds one cycle. Outputs are held stable while waiting.
- opCode is sampled only in DECODE and MEM_ADDR. IR is stable after FETCH.
- instr_count increments on the edge after instr_done and wraps 2^CNT_W-1 -> 0.
- Reset mid-instruction: the next state is FETCH with no write strobes in the reset cycle. A pending memory access is abandoned.
- States 12-15 are unused. An unused state goes to FETCH on the next edge, outputs 0 (12 excepted when the optional feature is compiled in).

Optional Feature:
Macro ILLEGAL_TRAP_EN.
- Defined: an unknown opcode in DECODE goes to TRAP(12). TRAP sets illegal_instr=1 (sticky) and drives all control outputs 0. There is no instr_done. The FSM stays in TRAP until reset.
- Undefined: an unknown opcode is a NOP (DECODE->FETCH, instr_done=1). illegal_instr is tied 0 and TRAP does not exist.

Test Plan:
- Reset 2 cycles, mem_ready=1, lw -> state 0,1,2,3,4,0; reg_write and mem_to_reg high only in state 4; instr_count=1.
- sw, mem_ready=0 for 3 cycles in MEM_WR -> mem_write and i_or_d high 4 consecutive cycles, then FETCH; instr_count +1.
- beq with zero=1 then zero=0 -> pc_write=1 with pc_source=01 in first BRANCH, pc_write=0 in second; both take 3 cycles.
- R-type then addi -> EXEC_R has alu_op=10, alu_src_b=00, R_WB has reg_dst=1. EXEC_I has alu_src_b=10, I_WB has reg_dst=0.
- opCode=111111 -> with ILLEGAL_TRAP_EN: state 12, illegal_instr=1 held until reset. Without it: back in FETCH after 2 cycles, instr_count +1.
- CNT_W=4, 16 j instructions -> instr_count wraps 15->0. Reset asserted in MEM_RD -> FETCH next cycle, instr_count=0, no reg_write.
